// File: rtl/dsp48a1_ctrl_pkg.sv
// Shared encodings for the DSP48A1 MAC sequencer: FSM states, OPMODE values
// and the per-sample tag that travels alongside the slice pipeline.
package dsp48a1_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // X=M with Z=0 loads the product into P; X=M with Z=P accumulates it.
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

  // Index of the P register stage for a given pipeline depth.
  function automatic int last_stage(input int pipe_lat);
    return pipe_lat - 1;
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Shift register of {valid, first} tags mirroring stages 1..PIPE_LAT-1 of the
// slice, so each stage's clock enable fires exactly when its operand arrives.
module mac_tag_pipe
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input  logic                CLK,
  input  logic                clr,
  input  tag_t                push_tag,
  output logic [PIPE_LAT-1:1] stage_valid,
  output logic                last_first,
  output logic                upstream_empty
);

  localparam int LAST = last_stage(PIPE_LAT);

  tag_t tag_q [1:LAST];

  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int k = 1; k <= LAST; k++) tag_q[k] <= '0;
    end else begin
      tag_q[1] <= push_tag;
      for (int k = 2; k <= LAST; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // upstream_empty ignores the P stage: once only that stage is busy, the
  // final CEP completes on this edge and the pipe is empty next cycle.
  always_comb begin
    stage_valid    = '0;
    upstream_empty = 1'b1;
    for (int k = 1; k <= LAST; k++) begin
      stage_valid[k] = tag_q[k].valid;
      if (k < LAST && tag_q[k].valid) upstream_empty = 1'b0;
    end
  end

  assign last_first = tag_q[LAST].first;

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Sequencer running one DSP48A1 slice as an N-tap MAC: takes samples over
// valid/ready, issues per-stage CEs and OPMODE, pulses done when P is final.
module dsp48a1_mac_seq
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [PIPE_LAT-1:0] ce_stage,
  output logic [7:0]          opmode,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state
);

  localparam int LAST = last_stage(PIPE_LAT);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic               accept;
  logic               last_accept;
  logic               abort_job;
  logic               pipe_clr;
  tag_t               push_tag;
  logic [PIPE_LAT-1:1] stage_valid;
  logic               last_first;
  logic               upstream_empty;

  // Handshake: a sample transfers in any cycle where in_valid and in_ready are
  // both high; in_ready depends only on state, never on in_valid.
  assign in_ready    = (state == ST_FEED);
  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (cnt == len_q - LEN_W'(1));
  assign abort_job   = abort && (state != ST_IDLE);
  assign pipe_clr    = RST | abort_job;

  assign push_tag = tag_t'{valid: accept, first: (cnt == '0)};

  mac_tag_pipe #(.PIPE_LAT(PIPE_LAT)) u_tag_pipe (
    .CLK           (CLK),
    .clr           (pipe_clr),
    .push_tag      (push_tag),
    .stage_valid   (stage_valid),
    .last_first    (last_first),
    .upstream_empty(upstream_empty)
  );

  assign ce_stage  = {stage_valid, accept};
  assign opmode    = (stage_valid[LAST] && last_first) ? OPM_LOAD : OPM_ACC;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) && !abort;
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      len_q <= '0;
      cnt   <= '0;
    end else if (abort_job) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort && len != '0) begin
            len_q <= len;
            cnt   <= '0;
            state <= ST_FEED;
          end
        end
        ST_FEED: begin
          // cnt tops out at len-1 before leaving FEED, so len=2^LEN_W-1 never wraps.
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (last_accept) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (upstream_empty) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Bench for dsp48a1_mac_seq: literal vector table, directed corner sequences and
// randomized jobs against an event-level model plus a behavioural slice for P.
module tb_dsp48a1_mac_seq;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIPE_LAT-1:0] ce_stage;
  logic [7:0]       opmode;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  always #5 CLK = ~CLK;

  dsp48a1_mac_seq #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ce_stage (ce_stage),
    .opmode   (opmode),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural DSP48A1 slice (A*B into P) ----------------
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic [31:0] sl_r0 = '0, sl_r1 = '0, sl_r2 = '0, sl_p = '0;

  always @(posedge CLK) begin
    if (ce_stage[0] === 1'b1) sl_r0 <= 32'(op_a) * 32'(op_b);
    if (ce_stage[1] === 1'b1) sl_r1 <= sl_r0;
    if (ce_stage[2] === 1'b1) sl_r2 <= sl_r1;
    if (ce_stage[3] === 1'b1) sl_p  <= (opmode == 8'h01) ? sl_r2 : sl_p + sl_r2;
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int c;
    bit first;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] exp_q[$];
  bit          m_busy = 0;
  bit          m_feed = 0;
  int          m_len = 0;
  int          m_cnt = 0;
  int          m_done_at = -1;
  logic [31:0] m_sum = '0;

  logic        s_rdy, s_busy, s_done;
  logic [3:0]  s_ce;
  logic [7:0]  s_opm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit acc_at(input int c, output bit first);
    first = 1'b0;
    foreach (acc_q[i]) begin
      if (acc_q[i].c == c) begin
        first = acc_q[i].first;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs, sample and check outputs, advance the model.
  task automatic step(input bit rs, input bit st, input logic [7:0] ln, input bit iv, input bit ab);
    logic [3:0]  e_ce;
    logic [7:0]  e_opm;
    logic        e_rdy, e_busy, e_done;
    bit          f;
    logic [31:0] exp_sum;
    @(negedge CLK);
    RST = rs; start = st; len = ln; in_valid = iv; abort = ab;
    op_a = 8'($urandom_range(0, 255));
    op_b = 8'($urandom_range(0, 255));
    #1;
    s_rdy = in_ready; s_ce = ce_stage; s_opm = opmode; s_busy = busy; s_done = done;

    e_rdy  = m_feed;
    e_ce   = '0;
    e_ce[0] = m_feed & iv;
    e_opm  = 8'h09;
    for (int k = 1; k < PIPE_LAT; k++) begin
      if (acc_at(cyc - k, f)) begin
        e_ce[k] = 1'b1;
        if (k == PIPE_LAT - 1 && f) e_opm = 8'h01;
      end
    end
    e_busy = m_busy;
    e_done = m_busy && (cyc == m_done_at) && !ab;
    check("outputs{rdy,ce,opm,busy,done}", {17'b0, s_rdy, s_ce, s_opm, s_busy, s_done},
          {17'b0, e_rdy, e_ce, e_opm, e_busy, e_done});
    if (e_done) begin
      exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("p_sum", sl_p, exp_sum);
    end

    if (rs || (ab && m_busy)) begin
      m_busy = 0; m_feed = 0; m_done_at = -1;
      acc_q.delete(); exp_q.delete();
    end else if (!m_busy) begin
      if (st && ln != 0 && !ab) begin
        m_busy = 1; m_feed = 1; m_len = ln; m_cnt = 0; m_sum = '0; m_done_at = -1;
        acc_q.delete();
      end
    end else if (m_feed) begin
      if (iv) begin
        acc_q.push_back('{c: cyc, first: (m_cnt == 0)});
        m_sum += 32'(op_a) * 32'(op_b);
        m_cnt++;
        if (m_cnt == m_len) begin
          m_feed = 0;
          m_done_at = cyc + PIPE_LAT;
          exp_q.push_back(m_sum);
        end
      end
    end else if (cyc == m_done_at) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, 0, 0);
  endtask

  // ---------------- literal vector table ----------------
  typedef struct {
    bit         st;
    logic [7:0] ln;
    bit         iv;
    logic [3:0] ce;
    logic [7:0] opm;
    bit         busy;
    bit         done;
    bit         rdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // len=3 back to back, then len=1
    tbl[0]  = '{1, 8'd3, 0, 4'b0000, 8'h09, 0, 0, 0};
    tbl[1]  = '{0, 8'd0, 1, 4'b0001, 8'h09, 1, 0, 1};
    tbl[2]  = '{0, 8'd0, 1, 4'b0011, 8'h09, 1, 0, 1};
    tbl[3]  = '{0, 8'd0, 1, 4'b0111, 8'h09, 1, 0, 1};
    tbl[4]  = '{0, 8'd0, 0, 4'b1110, 8'h01, 1, 0, 0};
    tbl[5]  = '{0, 8'd0, 0, 4'b1100, 8'h09, 1, 0, 0};
    tbl[6]  = '{0, 8'd0, 0, 4'b1000, 8'h09, 1, 0, 0};
    tbl[7]  = '{0, 8'd0, 0, 4'b0000, 8'h09, 1, 1, 0};
    tbl[8]  = '{0, 8'd0, 0, 4'b0000, 8'h09, 0, 0, 0};
    tbl[9]  = '{1, 8'd1, 0, 4'b0000, 8'h09, 0, 0, 0};
    tbl[10] = '{0, 8'd0, 1, 4'b0001, 8'h09, 1, 0, 1};
    tbl[11] = '{0, 8'd0, 0, 4'b0010, 8'h09, 1, 0, 0};
    tbl[12] = '{0, 8'd0, 0, 4'b0100, 8'h09, 1, 0, 0};
    tbl[13] = '{0, 8'd0, 0, 4'b1000, 8'h01, 1, 0, 0};
    tbl[14] = '{0, 8'd0, 0, 4'b0000, 8'h09, 1, 1, 0};
    tbl[15] = '{0, 8'd0, 0, 4'b0000, 8'h09, 0, 0, 0};

    repeat (2) @(posedge CLK);
    step(1, 0, 8'd0, 0, 0);   // reset values while RST held
    step(0, 0, 8'd0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].st, tbl[i].ln, tbl[i].iv, 0);
      check($sformatf("tbl[%0d]{rdy,ce,opm,busy,done}", i),
            {17'b0, s_rdy, s_ce, s_opm, s_busy, s_done},
            {17'b0, tbl[i].rdy, tbl[i].ce, tbl[i].opm, tbl[i].busy, tbl[i].done});
    end

    // bubble: in_valid 1,0,1,1
    step(0, 1, 8'd3, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 1, 0);
    idle(6);

    // abort two cycles after the second accept of a len=5 job
    step(0, 1, 8'd5, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 0, 0);
    step(0, 0, 8'd0, 0, 1);
    step(0, 0, 8'd0, 0, 0);
    check("after_abort{busy,ce}", {27'b0, s_busy, s_ce}, 32'h0);
    idle(5);
    step(0, 1, 8'd2, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 1, 0);
    idle(6);

    // len=0 start ignored; start during FEED ignored
    step(0, 1, 8'd0, 1, 0);
    step(0, 0, 8'd0, 0, 0);
    step(0, 1, 8'd3, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 1, 8'd7, 1, 0);
    step(0, 1, 8'd1, 1, 0);
    idle(6);

    // start together with abort in IDLE
    step(0, 1, 8'd4, 0, 1);
    idle(2);

    // RST in DRAIN
    step(0, 1, 8'd2, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 0, 0);
    step(1, 0, 8'd0, 0, 0);
    step(0, 0, 8'd0, 0, 0);
    check("after_rst{rdy,ce,opm,busy,done}", {17'b0, s_rdy, s_ce, s_opm, s_busy, s_done},
          {17'b0, 1'b0, 4'b0000, 8'h09, 1'b0, 1'b0});
    idle(6);

    // maximum length, with occasional bubbles
    step(0, 1, 8'hFF, 0, 0);
    for (int i = 0; i < 400 && m_busy; i++) step(0, 0, 8'd0, ($urandom_range(0, 7) != 0), 0);
    if (m_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL max_len_timeout cyc=%0d actual=busy required=idle", cyc);
    end
    idle(2);

    // randomized jobs with noise on start/len and rare aborts
    for (int j = 0; j < 40; j++) begin
      int guard;
      guard = 0;
      step(0, 1, 8'($urandom_range(1, 12)), 0, 0);
      while (m_busy && guard < 400) begin
        step(0, $urandom_range(0, 1), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        guard++;
      end
      if (guard >= 400) begin
        n_cmp++; n_bad++;
        $display("FAIL rand_job_timeout cyc=%0d actual=busy required=idle", cyc);
      end
      step(0, 0, 8'd0, 0, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
